// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: access size and FSM state encodings.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_access_pkg;

   // Access size as carried on req_size
   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } mem_size_t;

   // Request sequencing states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } mas_state_t;

endpackage

// File: rtl/mem_lane_format.sv
// Load extension and read-modify-write byte merge for the low 1/2/4/8 bytes.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module mem_lane_format
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [63:0] rdata,
   input  logic [63:0] wdata,
   output logic [63:0] ext_out,
   output logic [63:0] merge_out
);

   // Select the lane width; doublewords pass straight through both paths
   always_comb begin
      ext_out   = rdata;
      merge_out = wdata;
      case (mem_size_t'(size))
         SZ_B: begin
            ext_out   = {{56{~is_unsigned & rdata[7]}}, rdata[7:0]};
            merge_out = {rdata[63:8], wdata[7:0]};
         end
         SZ_H: begin
            ext_out   = {{48{~is_unsigned & rdata[15]}}, rdata[15:0]};
            merge_out = {rdata[63:16], wdata[15:0]};
         end
         SZ_W: begin
            ext_out   = {{32{~is_unsigned & rdata[31]}}, rdata[31:0]};
            merge_out = {rdata[63:32], wdata[31:0]};
         end
         default: begin
            ext_out   = rdata;
            merge_out = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for memory_64: one request at a time, sized loads, RMW partial stores.
// Latency from accept: load 3, doubleword store 2, partial store 4 cycles.
// Backpressure: req_ready low from accept until RESP completes; response cannot be stalled.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata
);

   mas_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] ext_val;
   logic [DATA_W-1:0] merge_val;

   mem_lane_format u_fmt (
      .size        (size_q),
      .is_unsigned (uns_q),
      .rdata       (mem_rdata),
      .wdata       (wdata_q),
      .ext_out     (ext_val),
      .merge_out   (merge_val)
   );

   // Both memory addresses track the latched request address; write data is the staged word
   assign mem_raddr  = addr_q;
   assign mem_waddr  = addr_q;
   assign mem_wdata  = wdata_q;
   assign resp_rdata = rdata_q;

   // Next-state and state-decoded outputs (mem_wr comes only from state_q, so no glitches)
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      uns_d      = uns_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_wr     = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               write_d = req_write;
               wdata_d = req_wdata;
               // A full doubleword store needs no read of the old contents
               if (req_write && (mem_size_t'(req_size) == SZ_D)) state_d = WRITE;
               else                                               state_d = READ;
            end
         end
         READ: state_d = DATA;
         DATA: begin
            if (write_q) begin
               wdata_d = merge_val;
               state_d = WRITE;
            end else begin
               rdata_d = ext_val;
               state_d = RESP;
            end
         end
         WRITE: begin
            mem_wr  = 1'b1;
            rdata_d = '0;   // store responses report zero
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and request registers; reset aborts any in-flight request without a response
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
